// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the switch debounce bank.
//   DEF_*     : default parameter values used by debounce_bank / debounce_channel
//   cnt_width : bit width needed to hold a counter value of 0..limit inclusive
package debounce_pkg;

    localparam int unsigned DEF_NUM_CH         = 4;
    localparam int unsigned DEF_DEBOUNCE_LIMIT = 250_000;
    localparam int unsigned DEF_HOLD_LIMIT     = 25_000_000;
    localparam int unsigned DEF_SYNC_STAGES    = 2;

    // Width of a counter that must represent every value from 0 up to limit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchroniser, debounce filter, edge pulses and hold detect.
// Ports:
//   i_Clk    : system clock, rising edge
//   i_Rst_L  : synchronous active-low reset
//   i_Switch : raw asynchronous switch level
//   o_Switch : debounced level
//   o_Rise   : one-cycle pulse on the first cycle o_Switch shows 1
//   o_Fall   : one-cycle pulse on the first cycle o_Switch shows 0
//   o_Hold   : one-cycle pulse once o_Switch has been 1 for HOLD_LIMIT cycles
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int unsigned HOLD_LIMIT     = DEF_HOLD_LIMIT,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Hold
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_LIMIT);
    localparam int unsigned HW = cnt_width(HOLD_LIMIT);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_LIMIT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LIMIT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_LIMIT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          db_cnt_q, db_cnt_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic                   sw_q, sw_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   hold_q, hold_d;
    logic                   s;
    logic                   differ;
    logic                   load;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        differ = (s != sw_q);
        // Accept the new level on the cycle the count has already seen LIMIT-1 differing cycles.
        load   = differ && (db_cnt_q == DB_LAST);

        db_cnt_d = '0;
        if (differ && !load) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        sw_d   = load ? s : sw_q;
        rise_d = load && s;
        fall_d = load && !s;

        hold_cnt_d = hold_cnt_q;
        if (!sw_q) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end

        // A release landing on the same edge wins, so hold and fall never coincide.
        hold_d = sw_q && (hold_cnt_q == HOLD_LAST) && !load;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            sw_q       <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], i_Switch};
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            sw_q       <= sw_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            hold_q     <= hold_d;
        end
    end

    assign o_Switch = sw_q;
    assign o_Rise   = rise_q;
    assign o_Fall   = fall_q;
    assign o_Hold   = hold_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of NUM_CH independent debounced switch channels.
// Ports:
//   i_Clk    : system clock, rising edge
//   i_Rst_L  : synchronous active-low reset
//   i_Switch : raw switch levels, bit n = channel n
//   o_Switch : debounced levels
//   o_Rise   : per-channel 0->1 pulses
//   o_Fall   : per-channel 1->0 pulses
//   o_Hold   : per-channel long-press pulses
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH         = DEF_NUM_CH,
    parameter int unsigned DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int unsigned HOLD_LIMIT     = DEF_HOLD_LIMIT,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Hold
);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .HOLD_LIMIT     (HOLD_LIMIT),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_chan (
            .i_Clk    (i_Clk),
            .i_Rst_L  (i_Rst_L),
            .i_Switch (i_Switch[n]),
            .o_Switch (o_Switch[n]),
            .o_Rise   (o_Rise[n]),
            .o_Fall   (o_Fall[n]),
            .o_Hold   (o_Hold[n])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with NUM_CH=4, DEBOUNCE_LIMIT=4, HOLD_LIMIT=10,
// SYNC_STAGES=2. A raw change applied just after an edge shows on o_Switch after 6 edges.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [3:0] sw_in;
    logic [3:0] o_sw, o_rise, o_fall, o_hold;

    int total = 0;
    int bad   = 0;

    debounce_bank #(
        .NUM_CH         (4),
        .DEBOUNCE_LIMIT (4),
        .HOLD_LIMIT     (10),
        .SYNC_STAGES    (2)
    ) u_dut (
        .i_Clk    (clk),
        .i_Rst_L  (rst_l),
        .i_Switch (sw_in),
        .o_Switch (o_sw),
        .o_Rise   (o_rise),
        .o_Fall   (o_fall),
        .o_Hold   (o_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge, then compare all four output vectors.
    task automatic step_chk(input string tag, input logic [3:0] esw, input logic [3:0] erise,
                            input logic [3:0] efall, input logic [3:0] ehold);
        @(posedge clk);
        #1;
        check({tag, ".sw"},   o_sw,   esw);
        check({tag, ".rise"}, o_rise, erise);
        check({tag, ".fall"}, o_fall, efall);
        check({tag, ".hold"}, o_hold, ehold);
    endtask

    // ncyc checked cycles; channels in m move to level 'up' at cycle ev (from base),
    // with a hold pulse on m at cycle hc. ev/hc beyond ncyc means no event.
    task automatic seg(input string tag, input int ncyc, input logic [3:0] base,
                       input logic [3:0] m, input int ev, input logic up, input int hc);
        logic [3:0] esw, er, ef, eh;
        for (int c = 1; c <= ncyc; c++) begin
            esw = base;
            if (c >= ev) esw = up ? (base | m) : (base & ~m);
            er = (c == ev && up)  ? m : 4'b0000;
            ef = (c == ev && !up) ? m : 4'b0000;
            eh = (c == hc)        ? m : 4'b0000;
            step_chk($sformatf("%s.c%0d", tag, c), esw, er, ef, eh);
        end
    endtask

    initial begin
        rst_l = 1'b0;
        sw_in = 4'b0000;
        seg("rst", 3, 4'b0000, 4'b0000, 99, 1'b1, 99);
        rst_l = 1'b1;
        seg("idle", 4, 4'b0000, 4'b0000, 99, 1'b1, 99);

        // Clean step on ch0; release so the fall lands on the edge the hold would fire.
        sw_in = 4'b0001;
        seg("ch0_up", 10, 4'b0000, 4'b0001, 6, 1'b1, 99);
        sw_in = 4'b0000;
        seg("ch0_dn", 10, 4'b0001, 4'b0001, 6, 1'b0, 99);

        // Bounce on ch1, then steady high.
        sw_in = 4'b0010; seg("ch1_b0", 1, 4'b0000, 4'b0000, 99, 1'b1, 99);
        sw_in = 4'b0000; seg("ch1_b1", 1, 4'b0000, 4'b0000, 99, 1'b1, 99);
        sw_in = 4'b0010; seg("ch1_b2", 1, 4'b0000, 4'b0000, 99, 1'b1, 99);
        sw_in = 4'b0000; seg("ch1_b3", 1, 4'b0000, 4'b0000, 99, 1'b1, 99);
        sw_in = 4'b0010;
        seg("ch1_up", 8, 4'b0000, 4'b0010, 6, 1'b1, 99);
        sw_in = 4'b0000;
        seg("ch1_dn", 8, 4'b0010, 4'b0010, 6, 1'b0, 99);

        // Long press on ch2: one hold 10 cycles after the rise, then fall only.
        sw_in = 4'b0100;
        seg("ch2_up", 36, 4'b0000, 4'b0100, 6, 1'b1, 16);
        sw_in = 4'b0000;
        seg("ch2_dn", 8, 4'b0100, 4'b0100, 6, 1'b0, 99);

        // Three-cycle glitch on ch3 must be filtered.
        sw_in = 4'b1000;
        seg("ch3_g1", 3, 4'b0000, 4'b0000, 99, 1'b1, 99);
        sw_in = 4'b0000;
        seg("ch3_g2", 10, 4'b0000, 4'b0000, 99, 1'b1, 99);

        // All channels together, reset mid-hold, then fresh debounce of the held inputs.
        sw_in = 4'b1111;
        seg("all_up", 12, 4'b0000, 4'b1111, 6, 1'b1, 99);
        rst_l = 1'b0;
        seg("all_rst", 2, 4'b0000, 4'b0000, 99, 1'b1, 99);
        rst_l = 1'b1;
        seg("all_re", 20, 4'b0000, 4'b1111, 6, 1'b1, 16);
        sw_in = 4'b0000;
        seg("all_dn", 8, 4'b1111, 4'b1111, 6, 1'b0, 99);

        // Reset mid-debounce with input dropped: nothing may appear afterwards.
        sw_in = 4'b0001;
        seg("md_cnt", 4, 4'b0000, 4'b0000, 99, 1'b1, 99);
        rst_l = 1'b0;
        sw_in = 4'b0000;
        seg("md_rst", 1, 4'b0000, 4'b0000, 99, 1'b1, 99);
        rst_l = 1'b1;
        seg("md_after", 10, 4'b0000, 4'b0000, 99, 1'b1, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
